// File: rtl/flash_spi_arbiter_pkg.sv
// Shared flash package: requester indices, arbiter gap default, FSM encodings.
package flash_spi_arbiter_pkg;

  // Requester slots on the shared spi_master
  localparam logic [1:0] REQ_WRITE = 2'd0;  // flash_write
  localparam logic [1:0] REQ_READ  = 2'd1;  // flash_read
  localparam logic [1:0] REQ_ID    = 2'd2;  // flash_id

  // CS-high idle time after each released grant
  localparam int GAP_CYC_DEF = 16;

  // Arbiter FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // One-hot grant to requester index; zero maps to slot 0
  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/flash_spi_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: search starts just after last owner.
module rr_pick3
  import flash_spi_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [2:0] o_pick
);

  logic [1:0] w_ord [3];

  // Priority order rotated so the previous owner is checked last
  always_comb begin
    case (i_last)
      REQ_WRITE: begin w_ord[0] = REQ_READ;  w_ord[1] = REQ_ID;    w_ord[2] = REQ_WRITE; end
      REQ_READ:  begin w_ord[0] = REQ_ID;    w_ord[1] = REQ_WRITE; w_ord[2] = REQ_READ;  end
      default:   begin w_ord[0] = REQ_WRITE; w_ord[1] = REQ_READ;  w_ord[2] = REQ_ID;    end
    endcase
  end

  // First requesting slot in rotated order wins
  always_comb begin
    o_pick = 3'b000;
    if (i_req[w_ord[0]])      o_pick[w_ord[0]] = 1'b1;
    else if (i_req[w_ord[1]]) o_pick[w_ord[1]] = 1'b1;
    else if (i_req[w_ord[2]]) o_pick[w_ord[2]] = 1'b1;
  end

endmodule

// File: rtl/flash_spi_arbiter.sv
// Arbitrates flash_write / flash_read / flash_id onto one spi_master.
// An owner keeps the bus until its req drops, then CS is held high for GAP_CYC.
module flash_spi_arbiter
  import flash_spi_arbiter_pkg::*;
#(
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] tx_din0,
  input  logic [7:0] tx_din1,
  input  logic [7:0] tx_din2,
  output logic [2:0] trans_done_o,
  output logic [7:0] rx_dout,
  output logic       m_trans_req,
  output logic [7:0] m_tx_dout,
  input  logic [7:0] m_rx_din,
  input  logic       m_trans_done,
  output logic [2:0] grant,
  output logic       busy
);

  localparam int CW = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  logic [1:0]      r_state;
  logic [2:0]      r_grant;
  logic [1:0]      r_owner;
  logic [1:0]      r_last;
  logic [CW-1:0]   r_gap_cnt;
  logic [2:0]      w_pick;
  logic [2:0][7:0] w_tx_din;
  logic            w_in_grant;

  assign w_tx_din   = {tx_din2, tx_din1, tx_din0};
  assign w_in_grant = (r_state == ST_GRANT);

  rr_pick3 u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  // FSM: IDLE picks an owner, GRANT holds until owner's req drops, GAP idles CS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= 3'b000;
      r_owner   <= REQ_WRITE;
      r_last    <= REQ_ID;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant <= w_pick;
            r_owner <= onehot_idx(w_pick);
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[r_owner]) begin
            r_grant <= 3'b000;
            r_last  <= r_owner;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_grant   <= 3'b000;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  // Owner path muxing; everything is gated by GRANT so reset drops it at once
  always_comb begin
    m_trans_req  = w_in_grant & req[r_owner];
    m_tx_dout    = w_in_grant ? w_tx_din[r_owner] : 8'h00;
    trans_done_o = w_in_grant ? (r_grant & {3{m_trans_done}}) : 3'b000;
  end

  assign rx_dout = m_rx_din;
  assign grant   = r_grant;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: doc/flash_spi_arbiter.md
FLASH_SPI_ARBITER -- requirements
Module: flash_spi_arbiter

Interface
REQ-001 Parameter GAP_CYC, default 16, SHALL set the number of idle cycles, with m_trans_req low, inserted after each released grant (CS high time).
REQ-002 clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req  input  3  SHALL carry the trans_req of requester 0 (flash_write), 1 (flash_read), 2 (flash_id).
REQ-005 tx_din0, tx_din1, tx_din2  input  8 each  SHALL carry the tx byte of each requester.
REQ-006 trans_done_o  output  3  SHALL be the per-requester trans_done.
REQ-007 rx_dout  output  8  SHALL be the received byte, broadcast to all requesters.
REQ-008 m_trans_req  output  1  SHALL be the trans_req to spi_master.
REQ-009 m_tx_dout  output  8  SHALL be the tx byte to spi_master.
REQ-010 m_rx_din  input  8  SHALL be the rx byte from spi_master.
REQ-011 m_trans_done  input  1  SHALL be the byte-complete strobe from spi_master.
REQ-012 grant  output  3  SHALL be the one-hot current owner; 0 when none.
REQ-013 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-014 The arbiter SHALL implement states IDLE, GRANT and GAP.
REQ-015 IDLE: when req is nonzero, the arbiter SHALL select one requester by round-robin, starting after last_owner, and enter GRANT next cycle with grant registered (1-cycle grant latency).
REQ-016 IDLE with req equal to 0 SHALL stay in IDLE with grant held at 0.
REQ-017 GRANT: m_trans_req SHALL equal req[owner], combinational, and m_tx_dout SHALL equal tx_din[owner].
REQ-018 Outside GRANT, m_trans_req SHALL be 0 and m_tx_dout SHALL be 8'h00.
REQ-019 trans_done_o[owner] SHALL equal m_trans_done in GRANT; all other trans_done_o bits SHALL be 0 at all times.
REQ-020 rx_dout SHALL equal m_rx_din unconditionally.
REQ-021 GRANT: when req[owner] is 0 on a cycle, the next state SHALL be GAP, grant SHALL clear and last_owner SHALL update to owner.
REQ-022 Requests from non-owners during GRANT SHALL have no effect on the owner or on the spi_master outputs.
REQ-023 GAP: a counter SHALL run 0..GAP_CYC-1; at terminal count the next state SHALL be IDLE, and the counter SHALL clear.
REQ-024 Requests during GAP SHALL NOT be granted; they are sampled again in IDLE, so no requester loses a request.
REQ-025 m_trans_done asserted outside GRANT SHALL be ignored and not forwarded.
REQ-026 Requesters SHALL hold req until their sequence completes; a req deasserted before grant is not remembered.
REQ-027 The owner SHALL NOT change during a sequence; an owner's req may stay high indefinitely (no timeout).

Reset
REQ-028 On rst_n low, the state SHALL be IDLE, grant 0, last_owner 2 (so requester 0 has first priority), the gap counter 0, m_trans_req 0, m_tx_dout 0, trans_done_o 0 and busy 0.
REQ-029 Reset asserted mid-GRANT SHALL drop m_trans_req immediately, asynchronously, with no gap.

Structure
REQ-030 Requester indices, GAP_CYC default and state encodings SHALL reside in the shared flash package, used also by flash_write, flash_read and flash_id.
REQ-031 The round-robin selector SHALL be one sub-module, rr_pick3, that is combinational (req and last_owner in, one-hot out).

Verification
REQ-032 Reset, then req equal to 3'b111 in one cycle: the bench SHALL check grant is 3'b001 next cycle; after release and 16 GAP cycles, 3'b010; then 3'b100.
REQ-033 flash_write owns the bus and sends 06h; with m_trans_done pulsed once, the bench SHALL check trans_done_o is 3'b001 and bits 1 and 2 stay 0.
REQ-034 req[1] rises while owner is 0: the bench SHALL check m_tx_dout stays tx_din0 (for example 8'hD8) until req[0] falls, then that m_trans_req is 0 for exactly 16 cycles before grant becomes 3'b010.
REQ-035 A stray m_trans_done in IDLE: the bench SHALL check trans_done_o stays 3'b000.
REQ-036 rst_n is pulled low mid-GRANT with owner 2: the bench SHALL check m_trans_req and grant go to 0 at once, and after release req equal to 3'b101 is granted 3'b001.
